// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, PC select codes, fetch FSM states and queue entry type
package cpu_pkg;

  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  typedef enum logic [1:0] {
    SEL_INC   = 2'b00,
    SEL_START = 2'b01,
    SEL_LOAD  = 2'b11
  } sel_pc_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - 2-entry fetch queue with registered head, push/pop/flush and count
module fetch_buf
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [1:0]         count_o,
  output logic [ENTRY_W-1:0] head_o
);

  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  fetch_entry_t push_e;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;

  assign push_e  = push_data_i;
  assign pop_ok  = pop_i & (count_q != 2'd0);
  assign count_o = count_q;
  assign head_o  = head_q;

  // Next-state: flush wins; otherwise push and pop are both honoured in the same cycle
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_ok})
        2'b11: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = push_e;
          end else begin
            head_d = push_e;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = push_e;
          end else begin
            tail_d = push_e;
          end
          if (count_q != 2'd2) begin
            count_d = count_q + 2'd1;
          end
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Queue storage; reset clears the head so instr/instr_pc read zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A push into a full queue with no pop means the fetch credit accounting is broken
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push_i && !pop_ok && !flush_i && (count_q == 2'd2)));

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller; FETCH_PERF_EN adds perf_fetch/perf_stall counters
module fetch_ctrl
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic               halt,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [1:0]         sel_pc,
  output logic [ADDR_W-1:0]  ld_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch,
  output logic [31:0]        perf_stall
`endif
);

  fetch_state_e      state_q, state_d;
  logic              epoch_q, epoch_d;
  logic              inflight_q, inflight_d;
  logic              tag_epoch_q, tag_epoch_d;
  logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;

  sel_pc_e           sel_w;
  logic              flush_w;
  logic              issue_w;
  logic              can_issue_w;
  logic              pop_w;
  logic              push_w;
  logic [1:0]        count_w;
  logic [2:0]        occ_w;
  fetch_entry_t      push_e;
  fetch_entry_t      head_e;
  logic [ENTRY_W-1:0] head_w;

  // The memory is addressed straight from the PC; the PC itself is steered via sel_pc
  assign imem_addr   = pc_in;
  assign sel_pc      = sel_w;

  assign instr_valid = (count_w != 2'd0);
  assign head_e      = head_w;
  assign instr       = head_e.instr;
  assign instr_pc    = head_e.pc;
  assign pop_w       = instr_valid & instr_ready;

  // Credit: words queued plus the one in flight, less the word leaving this cycle
  assign occ_w       = {1'b0, count_w} + {2'b00, inflight_q};
  assign can_issue_w = (occ_w < (3'd2 + {2'b00, pop_w}));

  // A return is kept only if no redirect/flush happened since it was issued
  assign push_w       = inflight_q & (tag_epoch_q == epoch_q) & ~flush_w;
  assign push_e.instr = imem_rdata;
  assign push_e.pc    = tag_pc_q;

  // Control decode: halt > start > br_valid > issue > hold (PC reloaded with itself)
  always_comb begin
    state_d     = state_q;
    sel_w       = SEL_LOAD;
    ld_addr     = pc_in;
    flush_w     = 1'b0;
    issue_w     = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        sel_w   = SEL_START;
        ld_addr = start_addr;
        state_d = RUN;
      end
    end else if (halt) begin
      flush_w = 1'b1;
      state_d = IDLE;
    end else if (start) begin
      sel_w   = SEL_START;
      ld_addr = start_addr;
      flush_w = 1'b1;
    end else if (br_valid) begin
      ld_addr = br_target;
      flush_w = 1'b1;
    end else if (can_issue_w) begin
      sel_w   = SEL_INC;
      issue_w = 1'b1;
    end
    epoch_d     = flush_w ? ~epoch_q : epoch_q;
    inflight_d  = issue_w;
    tag_pc_d    = issue_w ? pc_in : tag_pc_q;
    tag_epoch_d = issue_w ? epoch_q : tag_epoch_q;
  end

  // FSM state, epoch and in-flight fetch tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      epoch_q     <= 1'b0;
      inflight_q  <= 1'b0;
      tag_epoch_q <= 1'b0;
      tag_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      epoch_q     <= epoch_d;
      inflight_q  <= inflight_d;
      tag_epoch_q <= tag_epoch_d;
      tag_pc_q    <= tag_pc_d;
    end
  end

  fetch_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_w),
    .push_i      (push_w),
    .push_data_i (push_e),
    .pop_i       (pop_w),
    .count_o     (count_w),
    .head_o      (head_w)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;
  logic        hold_w;

  assign hold_w     = (state_q == RUN) & ~halt & ~start & ~br_valid & ~can_issue_w;
  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;

  // Saturating counters of accepted words and RUN hold cycles; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (pop_w && (perf_fetch_q != 32'hFFFF_FFFF)) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (hold_w && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - fetch_ctrl bench: PC/memory environment, stream reference model, directed and random steps
module tb_fetch_ctrl;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [ADDR_W-1:0]  start_addr;
  logic               halt;
  logic [ADDR_W-1:0]  pc_in;
  logic [1:0]         sel_pc;
  logic [ADDR_W-1:0]  ld_addr;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               br_valid;
  logic [ADDR_W-1:0]  br_target;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]        perf_fetch;
  logic [31:0]        perf_stall;
`endif

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int age    = 100;
  logic              run_m = 1'b0;
  logic [ADDR_W-1:0] exp_next = '0;
  logic [ADDR_W-1:0] saved_pc;

  fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .halt        (halt),
    .pc_in       (pc_in),
    .sel_pc      (sel_pc),
    .ld_addr     (ld_addr),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch  (perf_fetch),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a ^ 11'h5A3, 10'h2AB, a};
  endfunction

  // PC register: cannot hold, only increment / load start / load ld_addr
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_in <= '0;
    end else begin
      case (sel_pc)
        2'b00:   pc_in <= pc_in + 11'd1;
        2'b01:   pc_in <= start_addr;
        2'b11:   pc_in <= ld_addr;
        default: pc_in <= pc_in;
      endcase
    end
  end

  // Synchronous instruction memory
  always @(posedge clk) begin
    imem_rdata <= mem_word(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the stream model, then advance the model
  task automatic cycle();
    #1;
    if (run_m && (age == 1 || age == 2)) chk("redirect_gap", 32'(instr_valid), 32'd0);
    if (run_m && age == 3)               chk("redirect_first", 32'(instr_valid), 32'd1);
    if (!run_m) begin
      chk("idle_valid", 32'(instr_valid), 32'd0);
    end else if (instr_valid) begin
      chk("instr_pc", 32'(instr_pc), 32'(exp_next));
      chk("instr", instr, mem_word(exp_next));
    end
    if (instr_valid && instr_ready) begin
      pops++;
      if (run_m) exp_next = exp_next + 11'd1;
    end
    if (!run_m) begin
      if (start) chk("idle_start_sel", 32'(sel_pc), 32'h1);
      else       chk("idle_hold", 32'((sel_pc == 2'b11) && (ld_addr == pc_in)), 32'd1);
    end else if (halt) begin
      chk("halt_hold", 32'((sel_pc == 2'b11) && (ld_addr == pc_in)), 32'd1);
    end else if (start) begin
      chk("run_start_sel", 32'(sel_pc), 32'h1);
    end else if (br_valid) begin
      chk("br_load", 32'((sel_pc == 2'b11) && (ld_addr == br_target)), 32'd1);
    end else begin
      chk("issue_or_hold", 32'((sel_pc == 2'b00) || ((sel_pc == 2'b11) && (ld_addr == pc_in))), 32'd1);
    end
    if (start) begin
      exp_next = start_addr;
      age      = 0;
      run_m    = 1'b1;
    end else if (run_m && halt) begin
      run_m = 1'b0;
      age   = 100;
    end else if (run_m && br_valid) begin
      exp_next = br_target;
      age      = 0;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    br_valid = 1'b0;
    halt     = 1'b0;
    if (age < 100) age++;
  endtask

  initial begin
    int n;
    int p0;
    int r;
    rst_n       = 1'b0;
    start       = 1'b0;
    start_addr  = '0;
    halt        = 1'b0;
    br_valid    = 1'b0;
    br_target   = '0;
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_sel", 32'(sel_pc), 32'h3);
    chk("rst_ld_addr", 32'(ld_addr), 32'(pc_in));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    // Start at 0x010 with decode always ready
    instr_ready = 1'b1;
    start = 1'b1; start_addr = 11'h010;
    cycle();
    n = 0;
    while (!(instr_valid && instr_pc == 11'h020) && n < 100) begin cycle(); n++; end
    chk("reach_020", 32'(instr_valid && instr_pc == 11'h020), 32'd1);

    // Backpressure for 5 cycles at 0x020
    instr_ready = 1'b0;
    repeat (4) cycle();
    #1;
    chk("bp_head", 32'(instr_pc), 32'h020);
    chk("bp_sel", 32'(sel_pc), 32'h3);
    chk("bp_ld_addr", 32'(ld_addr), 32'(pc_in));
    cycle();
    instr_ready = 1'b1;

    // Branch to 0x100 while 0x031 is in flight
    n = 0;
    while (!(instr_valid && instr_pc == 11'h030) && n < 100) begin cycle(); n++; end
    chk("reach_030", 32'(instr_valid && instr_pc == 11'h030), 32'd1);
    br_valid = 1'b1; br_target = 11'h100;
    cycle();
    repeat (2) cycle();
    chk("br_target_first", 32'(instr_valid && instr_pc == 11'h100), 32'd1);
    repeat (4) cycle();

    // halt and br_valid together: halt wins, PC held
    halt = 1'b1; br_valid = 1'b1; br_target = 11'h555;
    cycle();
    chk("halt_br_valid", 32'(instr_valid), 32'd0);
    saved_pc = pc_in;
    repeat (2) cycle();
    chk("halt_pc_held", 32'(pc_in), 32'(saved_pc));

    // start and br_valid together in RUN: start wins
    start = 1'b1; start_addr = 11'h200;
    cycle();
    repeat (5) cycle();
    start = 1'b1; start_addr = 11'h300; br_valid = 1'b1; br_target = 11'h150;
    #1;
    chk("start_br_sel", 32'(sel_pc), 32'h1);
    cycle();
    repeat (6) cycle();

    // Wrap-around from 0x7FE
    halt = 1'b1;
    cycle();
    start = 1'b1; start_addr = 11'h7FE;
    cycle();
    repeat (2) cycle();
    chk("wrap_7fe", 32'(instr_pc), 32'h7FE);
    cycle();
    chk("wrap_7ff", 32'(instr_pc), 32'h7FF);
    cycle();
    chk("wrap_000", 32'(instr_pc), 32'h000);
    repeat (3) cycle();

    // Randomised traffic
    p0 = pops;
    for (int i = 0; i < 600; i++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      if (!run_m) begin
        if ($urandom_range(0, 9) < 3) begin
          start = 1'b1; start_addr = 11'($urandom_range(0, 2047));
        end
      end else begin
        r = $urandom_range(0, 99);
        if (r < 2) begin
          halt = 1'b1;
        end else if (r < 4) begin
          start = 1'b1; start_addr = 11'($urandom_range(0, 2047));
        end else if (r < 10) begin
          br_valid = 1'b1; br_target = 11'($urandom_range(0, 2047));
        end
      end
      cycle();
    end
    chk("random_progress", 32'(pops > p0 + 100), 32'd1);

    // Asynchronous reset mid-stream
    instr_ready = 1'b1;
    start = 1'b1; start_addr = 11'h0A0;
    cycle();
    repeat (5) cycle();
    chk("pre_reset_valid", 32'(instr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_instr", instr, 32'd0);
    chk("async_instr_pc", 32'(instr_pc), 32'd0);
    chk("async_sel", 32'(sel_pc), 32'h3);
    chk("async_ld_addr", 32'(ld_addr), 32'(pc_in));
    run_m = 1'b0;
    age   = 100;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    chk("post_reset_valid", 32'(instr_valid), 32'd0);

`ifdef FETCH_PERF_EN
    chk("perf_fetch_rst", perf_fetch, 32'd0);
    start = 1'b1; start_addr = 11'h040;
    instr_ready = 1'b0;
    cycle();
    p0 = pops;
    n = 0;
    while ((pops - p0) < 10 && n < 100) begin
      instr_ready = 1'b1;
      cycle();
      n++;
      instr_ready = 1'b0;
    end
    instr_ready = 1'b0;
    repeat (2) cycle();
    chk("perf_fetch_10", perf_fetch, 32'd10);
    chk("perf_stall_nz", 32'(perf_stall != 32'd0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("perf_fetch_clr", perf_fetch, 32'd0);
    chk("perf_stall_clr", perf_stall, 32'd0);
    run_m = 1'b0;
    age   = 100;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
